// File: rtl/multimode_ff_bank_if.sv
// Control/data bundle for multimode_ff_bank.
// master drives en/mode/a/b/err_clr; slave returns state.
interface multimode_ff_bank_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             sr_err;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output en, mode, a, b, err_clr,
    input  q, qn, sr_err, chg_cnt
  );

  modport slave (
    input  en, mode, a, b, err_clr,
    output q, qn, sr_err, chg_cnt
  );
endinterface

// File: rtl/multimode_ff_bank.sv
// Vector of D/T/JK/SR flip-flops with a shared per-cycle mode.
// Optional saturating change counter: define MMFF_CHG_CNT_EN.
module multimode_ff_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input logic clk,
  input logic reset,
  multimode_ff_bank_if.slave bus
);
  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             err;
  logic             sr_bad;

  // S=R=1 bits fall into the hold term, so they keep q
  always_comb begin
    q_n = q;
    unique case (bus.mode)
      MODE_D:  q_n = bus.a;
      MODE_T:  q_n = q ^ bus.a;
      MODE_JK: q_n = (bus.a & ~q)
                   | (~bus.b & q);
      MODE_SR: q_n = (bus.a & ~bus.b)
                   | (q & ~(bus.a ^ bus.b));
      default: q_n = q;
    endcase
  end

  assign sr_bad = bus.en
                & (bus.mode == MODE_SR)
                & (|(bus.a & bus.b));

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (bus.en) begin
      q <= q_n;
    end
  end

  // set beats clear when both occur on one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (sr_bad) begin
      err <= 1'b1;
    end else if (bus.err_clr) begin
      err <= 1'b0;
    end
  end

`ifdef MMFF_CHG_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.en && (q_n != q)
                 && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.chg_cnt = cnt;
`else
  assign bus.chg_cnt = '0;
`endif

  assign bus.q      = q;
  assign bus.qn     = ~q;
  assign bus.sr_err = err;
endmodule

// File: tb/tb_multimode_ff_bank.sv
// Scoreboard bench for multimode_ff_bank.
// Reference model works bit by bit from the mode truth tables.
module tb_multimode_ff_bank;
  localparam int W = 4;
  localparam int C = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic         err;
    logic [C-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [W-1:0] m_q;
  logic         m_err;
  int           m_cnt;

  multimode_ff_bank_if #(.WIDTH(W), .CNT_W(C)) bus ();

  multimode_ff_bank #(
    .WIDTH(W),
    .RESET_VAL('0),
    .CNT_W(C)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_next(
    input logic [W-1:0] q,
    input logic [1:0]   md,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (md)
        2'd0: r[i] = a[i];
        2'd1: r[i] = q[i] ^ a[i];
        2'd2: begin
          if (a[i] && b[i])  r[i] = ~q[i];
          else if (a[i])     r[i] = 1'b1;
          else if (b[i])     r[i] = 1'b0;
          else               r[i] = q[i];
        end
        default: begin
          if (a[i] && !b[i]) r[i] = 1'b1;
          else if (b[i] && !a[i]) r[i] = 1'b0;
          else               r[i] = q[i];
        end
      endcase
    end
    return r;
  endfunction

  task automatic model_step(
    input logic rst, input logic en,
    input logic [1:0] md,
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic clr
  );
    logic [W-1:0] nq;
    exp_t e;
    if (rst) begin
      m_q = '0; m_err = 1'b0; m_cnt = 0;
    end else begin
      nq = en ? model_next(m_q, md, a, b) : m_q;
      if (clr) m_err = 1'b0;
      if (en && md == 2'd3 && (a & b) != 0)
        m_err = 1'b1;
`ifdef MMFF_CHG_CNT_EN
      if (en && nq != m_q && m_cnt < (1 << C) - 1)
        m_cnt++;
`endif
      m_q = nq;
    end
    e.q   = m_q;
    e.qn  = ~m_q;
    e.err = m_err;
    e.cnt = m_cnt[C-1:0];
    sb.push_back(e);
  endtask

  // one clock: drive now, model what the edge should produce
  task automatic cyc(
    input logic rst, input logic en,
    input logic [1:0] md,
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic clr
  );
    reset       = rst;
    bus.en      = en;
    bus.mode    = md;
    bus.a       = a;
    bus.b       = b;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    model_step(rst, en, md, a, b, clr);
  endtask

  task automatic lit(input string nm,
                     input logic [C-1:0] act,
                     input logic [C-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.q !== e.q) begin
          errors++;
          $display("FAIL q: got %h expected %h",
                   bus.q, e.q);
        end
        checks++;
        if (bus.qn !== e.qn) begin
          errors++;
          $display("FAIL qn: got %h expected %h",
                   bus.qn, e.qn);
        end
        checks++;
        if (bus.sr_err !== e.err) begin
          errors++;
          $display("FAIL sr_err: got %b expected %b",
                   bus.sr_err, e.err);
        end
        checks++;
        if (bus.chg_cnt !== e.cnt) begin
          errors++;
          $display("FAIL chg_cnt: got %h expected %h",
                   bus.chg_cnt, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    logic [C-1:0] sat;
`ifdef MMFF_CHG_CNT_EN
    sat = 8'd255;
`else
    sat = 8'd0;
`endif
    reset = 1'b1;
    bus.en = 1'b0;
    bus.mode = 2'd0;
    bus.a = '0;
    bus.b = '0;
    bus.err_clr = 1'b0;
    m_q = '0; m_err = 1'b0; m_cnt = 0;
    @(posedge clk);
    #1;
    cyc(1, 0, 2'd0, 4'h0, 4'h0, 0);
    lit("reset_q", {4'h0, bus.q}, 8'h00);
    lit("reset_qn", {4'h0, bus.qn}, 8'h0F);

    cyc(0, 1, 2'd0, 4'h5, 4'h0, 0);
    lit("d_load", {4'h0, bus.q}, 8'h05);
    cyc(0, 1, 2'd1, 4'h3, 4'h0, 0);
    lit("t_toggle", {4'h0, bus.q}, 8'h06);
    cyc(0, 0, 2'd0, 4'hF, 4'hF, 0);
    lit("en_hold", {4'h0, bus.q}, 8'h06);

    cyc(0, 1, 2'd2, 4'b1100, 4'b1010, 0);
    lit("jk", {4'h0, bus.q}, 8'h0C);

    cyc(0, 1, 2'd0, 4'h3, 4'h0, 0);
    cyc(0, 1, 2'd3, 4'b1001, 4'b0001, 0);
    lit("sr_forbid_q", {4'h0, bus.q}, 8'h0B);
    lit("sr_err_set", {7'h0, bus.sr_err}, 8'h01);
    cyc(0, 0, 2'd3, 4'hF, 4'hF, 0);
    lit("sr_err_sticky", {7'h0, bus.sr_err}, 8'h01);
    cyc(0, 0, 2'd0, 4'h0, 4'h0, 1);
    lit("sr_err_clr", {7'h0, bus.sr_err}, 8'h00);
    cyc(0, 1, 2'd3, 4'h1, 4'h1, 1);
    lit("sr_set_wins", {7'h0, bus.sr_err}, 8'h01);

    cyc(0, 1, 2'd0, 4'hA, 4'h0, 0);
    cyc(1, 1, 2'd3, 4'hF, 4'hF, 0);
    lit("rst_mid_q", {4'h0, bus.q}, 8'h00);
    lit("rst_mid_err", {7'h0, bus.sr_err}, 8'h00);
    lit("rst_mid_cnt", bus.chg_cnt, 8'h00);

    for (int i = 0; i < 300; i++)
      cyc(0, 1, 2'd1, 4'h1, 4'h0, 0);
    lit("cnt_sat", bus.chg_cnt, sat);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 2'd1, 4'hF, 4'h0, 0);
    lit("cnt_hold", bus.chg_cnt, sat);
    cyc(1, 0, 2'd0, 4'h0, 4'h0, 0);

    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)),
          4'($urandom), 4'($urandom),
          ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
